demux_stream: RTL



---
 rtl/demux_stream.sv | 88 ++++++++
 1 files changed

// File: rtl/demux_stream.sv
// Registered 1-to-CHANNELS stream demultiplexer with valid/ready handshaking,
// broadcast mode and a saturating counter of beats sent to non-existent channels.
module demux_stream #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned SEL_W    = 3,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      bcast,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]          drop_cnt
);

   logic [CHANNELS-1:0]       valid_q, valid_d;
   logic [CHANNELS*WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0]          drop_q, drop_d;
   logic [CHANNELS-1:0]       free, sel_hit, load;
   logic                      sel_ok, accept;

   // One-hot decode of sel; all-zero when sel names a channel that does not exist.
   always_comb begin
      sel_hit = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         sel_hit[c] = (32'(sel) == c);
      end
   end

   assign free   = ~valid_q | out_ready;
   assign sel_ok = |sel_hit;

   always_comb begin
      if (bcast) begin
         in_ready = &free;
      end else if (sel_ok) begin
         in_ready = |(free & sel_hit);
      end else begin
         in_ready = 1'b1;
      end
   end

   assign accept = in_valid & in_ready;

   always_comb begin
      load = '0;
      if (accept) begin
         load = bcast ? {CHANNELS{1'b1}} : sel_hit;
      end
   end

   always_comb begin
      valid_d = load | (valid_q & ~out_ready);
      data_d  = data_q;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (load[c]) begin
            data_d[c*WIDTH +: WIDTH] = in_data;
         end
      end
      drop_d = drop_q;
      if (accept && !bcast && !sel_ok && (drop_q != {CNT_W{1'b1}})) begin
         drop_d = drop_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
         drop_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         drop_q  <= drop_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign drop_cnt  = drop_q;

endmodule
